// File: rtl/vga_fetch_ctrl.sv
// Frame-buffer fetch controller: bus-master reads of the 1 bpp bitmap into a word FIFO,
// serialised into bytes for the display, restarting at base_addr on every vsync.
module vga_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned FIFO_LOG2   = 4,
  parameter int unsigned FRAME_WORDS = 9600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  vga_vsync,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_data,
  input  logic                  rd,
  output logic [7:0]            disp_data,
  output logic                  underrun,
  output logic [FIFO_LOG2:0]    fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned LVL_W = FIFO_LOG2 + 1;
  localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  vs_meta, vs_sync, vs_prev;
  logic                  frame_start;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      fetched_q;
  logic                  frame_done, has_room;
  logic                  push, pop, reload, req_d, addr_load;
  logic                  fifo_empty, rd_ok, underrun_d;
  logic [FIFO_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [1:0]            lane;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           head;

  // vsync synchroniser; flops idle high so reset never looks like a frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vga_vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_start = vs_prev & ~vs_sync;
  assign frame_done  = (fetched_q == CNT_W'(FRAME_WORDS));
  assign has_room    = (fifo_level < LVL_W'(DEPTH));
  assign fifo_empty  = (fifo_level == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_start)              state_d = IDLE;
        else if (frame_done)          state_d = DONE;
        else if (enable && has_room)  state_d = REQ;
      end
      REQ: begin
        if (frame_start)              state_d = bus_ack ? IDLE : DRAIN;
        else if (bus_ack)             state_d = IDLE;
      end
      DRAIN: if (bus_ack)             state_d = IDLE;
      DONE:  if (frame_start)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // DRAIN re-applies the reload when its abandoned bus cycle finally completes
  always_comb begin
    push      = 1'b0;
    reload    = frame_start;
    addr_load = 1'b0;
    case (state_q)
      IDLE:    addr_load = (state_d == REQ);
      REQ:     push      = bus_ack & ~frame_start;
      DRAIN:   reload    = frame_start | bus_ack;
      default: ;
    endcase
    req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req  <= 1'b0;
      bus_addr <= '0;
    end else begin
      bus_req <= req_d;
      if (addr_load) bus_addr <= addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      fetched_q <= '0;
    end else if (reload) begin
      addr_q    <= base_addr;
      fetched_q <= '0;
    end else if (push) begin
      addr_q    <= addr_q + ADDR_WIDTH'(1);
      fetched_q <= fetched_q + CNT_W'(1);
    end
  end

  // Byte serialiser: a flush in the same cycle swallows the rd
  assign rd_ok      = rd & ~fifo_empty & ~reload;
  assign pop        = rd_ok & (lane == 2'd3);
  assign underrun_d = rd & fifo_empty & ~reload;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lane       <= 2'd0;
      fifo_level <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= underrun_d;
      if (reload) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        lane       <= 2'd0;
        fifo_level <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + FIFO_LOG2'(1);
        if (pop)   rd_ptr <= rd_ptr + FIFO_LOG2'(1);
        if (rd_ok) lane   <= lane + 2'd1;
        if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
        else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign disp_data = fifo_empty ? 8'h00 : head[{lane, 3'b000} +: 8];

endmodule

// File: doc/vga_fetch_ctrl.md
# vga_fetch_ctrl

Bus-master fetch controller that feeds the bitmap video display. It streams the 1 bpp frame buffer from main memory into a small word FIFO, serialises the words into bytes for the display's `dispData`/`rd` interface, and restarts at the frame base address on every vertical sync. It sits in the CPU clock domain, between the shared memory bus arbiter and the video output stage.

## Interface
- `ADDR_WIDTH`, 30: word-address width of the memory bus.
- `FIFO_LOG2`, 4: log2 of FIFO depth in 32-bit words (default 16 words).
- `FRAME_WORDS`, 9600: words per frame (640x480 pixels / 32).
- `clk`  in  1  CPU clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when high, new bus requests are allowed.
- `base_addr`  in  ADDR_WIDTH  frame buffer word address, sampled at frame start.
- `vga_vsync`  in  1  raw active-low vsync from the pixel domain; synchronised internally.
- `bus_req`  out  1  read request, held until `bus_ack`.
- `bus_addr`  out  ADDR_WIDTH  word address of the request, stable while `bus_req` is high.
- `bus_ack`  in  1  one-cycle strobe; `bus_data` is valid in the same cycle.
- `bus_data`  in  32  read data.
- `rd`  in  1  one-cycle pulse from the display: the current byte has been consumed.
- `disp_data`  out  8  current display byte.
- `underrun`  out  1  one-cycle pulse: `rd` arrived while the FIFO was empty.
- `fifo_level`  out  FIFO_LOG2+1  number of words held in the FIFO.

## Operation
- Frame start:
  - `vga_vsync` passes through a 2-FF synchroniser followed by a falling-edge detect.
  - On the edge: flush the FIFO (level 0), byte lane 0, `addr` <= `base_addr`, `fetched` <= 0.
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE:
  - Go to DONE when `fetched` == FRAME_WORDS.
  - Otherwise go to REQ when `enable` and `fifo_level` < 2^FIFO_LOG2.
  - `bus_req` rises on the transition cycle.
- REQ:
  - Hold `bus_req` = 1 and `bus_addr` = `addr`.
  - On `bus_ack`: push `bus_data`, `addr`++ (wraps modulo 2^ADDR_WIDTH), `fetched`++, drop `bus_req`, go to IDLE.
- DRAIN:
  - Entered when a frame start hits while in REQ. The bus cycle is never aborted.
  - Keep `bus_req` = 1 until `bus_ack`. Discard that data, apply the frame-start reload, then go to IDLE.
- DONE: no requests. Go to IDLE on frame start (reload applied).
- Frame start in IDLE or DONE: reload immediately and go to IDLE.
- `enable` low:
  - Takes effect only in IDLE.
  - An in-flight REQ completes normally.
  - Frame starts still flush and reload.
- Byte serialiser:
  - `disp_data` = FIFO head byte[lane], little-endian (lane 0 = bits 7:0). It is combinational from head and lane, and 0 when the FIFO is empty.
  - `rd` with FIFO non-empty: lane++. When lane wraps 3 -> 0, pop the head word.
  - `rd` with FIFO empty: pulse `underrun`; lane unchanged.
- Simultaneous push and pop: both happen; `fifo_level` is unchanged.
- Frame start in the same cycle as `rd` or `bus_ack`: the flush wins. That `rd` is ignored. In REQ, that ack completes the cycle with its data discarded and goes to IDLE. No DRAIN is entered.
- A request is only issued with a free slot and at most one request is outstanding, so a push never overflows.

## Timing
- Reset values:
  - Outputs: `bus_req` 0, `bus_addr` 0, `disp_data` 0, `underrun` 0, `fifo_level` 0.
  - Internal: state IDLE, lane 0, `fetched` 0, synchroniser flops 1 (vsync inactive).
- Frame start latency: the reload takes effect on the 3rd `clk` edge after `vga_vsync` falls (2 sync stages + edge register).
- Request issue: IDLE -> REQ, `bus_req` high 1 cycle after the decision.
- Fetch timing:
  - `bus_ack` to FIFO push: written at the ack edge; `fifo_level` reflects it the next cycle.
  - Minimum 2 cycles per word (REQ with immediate ack, then IDLE).
- `rd` to `disp_data`: new byte visible the cycle after the `rd` edge.
- `underrun` is a registered pulse, 1 cycle after the offending `rd`.
- `rd` must be at least 2 cycles apart; the display synchroniser already guarantees this.

## Test plan
- Reset, then vsync edge with `base_addr`=0x1000 and zero-wait ack -> first `bus_addr`=0x1000 on the 4th cycle; addresses increment by 1; requests stop when `fifo_level`=16.
- FIFO holds word 0x44332211 and `rd` is pulsed 4 times -> `disp_data` reads 0x11, 0x22, 0x33, 0x44; the word pops after the 4th `rd`; `fifo_level` drops by 1.
- FRAME_WORDS=8, continuous `rd` -> exactly 8 `bus_req` cycles, then DONE with `bus_req` held 0 until the next vsync edge.
- Vsync edge while in REQ with `bus_ack` delayed 5 cycles -> `bus_req` held through the delay, acked data discarded, next request at the new `base_addr`, `fifo_level`=0.
- `rd` with empty FIFO (`enable`=0) -> `underrun` pulses once, `disp_data`=0, lane unchanged.
- `reset` asserted mid-REQ -> all outputs return to their reset values immediately, with no wait for a clock edge.
